// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter_if
// Description : Bus bundle between the core/MDU side and the write-back
//               arbiter: write requests, MDU handshake, issue tracking,
//               source-operand hazard query and the register-file write port.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if;
  logic        i_core_wren;
  logic [4:0]  i_core_rd_addr;
  logic [31:0] i_core_rd_data;
  logic        i_mdu_valid;
  logic [4:0]  i_mdu_rd_addr;
  logic [31:0] i_mdu_rd_data;
  logic        o_mdu_ready;
  logic        i_issue_valid;
  logic [4:0]  i_issue_rd_addr;
  logic [4:0]  i_rs1_addr;
  logic [4:0]  i_rs2_addr;
  logic        o_hazard;
  logic        o_core_stall;
  logic [31:0] o_busy_mask;
  logic        o_rd_wren;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;

  // Arbiter side
  modport slave (
    input  i_core_wren, i_core_rd_addr, i_core_rd_data,
    input  i_mdu_valid, i_mdu_rd_addr, i_mdu_rd_data,
    input  i_issue_valid, i_issue_rd_addr, i_rs1_addr, i_rs2_addr,
    output o_mdu_ready, o_hazard, o_core_stall, o_busy_mask,
    output o_rd_wren, o_rd_addr, o_rd_data
  );

  // Core / MDU side
  modport master (
    output i_core_wren, i_core_rd_addr, i_core_rd_data,
    output i_mdu_valid, i_mdu_rd_addr, i_mdu_rd_data,
    output i_issue_valid, i_issue_rd_addr, i_rs1_addr, i_rs2_addr,
    input  o_mdu_ready, o_hazard, o_core_stall, o_busy_mask,
    input  o_rd_wren, o_rd_addr, o_rd_data
  );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Merges the core single-cycle result path and the multi-cycle
//               MDU result path onto the single register-file write port,
//               keeps a scoreboard of registers awaiting an MDU result and
//               forces the MDU through after STARVE_LIMIT waiting cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4  // legal range 1..15
) (
  input  wire logic          i_clk,
  input  wire logic          i_reset,
  regfile_wb_arbiter_if.slave bus
);

  localparam logic [3:0] c_limit = 4'(STARVE_LIMIT);

  logic [3:0]  r_wait_cnt;
  logic [31:0] r_busy;
  logic [31:0] w_busy_nxt;
  logic        w_force;
  logic        w_grant_core;
  logic        w_grant_mdu;

  // Grant selection; reset suppresses every grant so no write or handshake
  // can complete while reset is asserted.
  always_comb begin
    w_force      = 1'b0;
    w_grant_core = 1'b0;
    w_grant_mdu  = 1'b0;
    if (!i_reset) begin
      w_force = bus.i_mdu_valid && (r_wait_cnt == c_limit);
      if (w_force) begin
        w_grant_mdu = 1'b1;
      end else if (bus.i_core_wren) begin
        w_grant_core = 1'b1;
      end else if (bus.i_mdu_valid) begin
        w_grant_mdu = 1'b1;
      end
    end
  end

  // Write-port mux, handshake, stall and hazard outputs.
  always_comb begin
    bus.o_rd_wren    = 1'b0;
    bus.o_rd_addr    = 5'd0;
    bus.o_rd_data    = 32'd0;
    bus.o_mdu_ready  = w_grant_mdu;
    bus.o_core_stall = w_force && bus.i_core_wren;
    bus.o_hazard     = 1'b0;
    if (w_grant_mdu) begin
      bus.o_rd_addr = bus.i_mdu_rd_addr;
      bus.o_rd_data = bus.i_mdu_rd_data;
      bus.o_rd_wren = (bus.i_mdu_rd_addr != 5'd0);
    end else if (w_grant_core) begin
      bus.o_rd_addr = bus.i_core_rd_addr;
      bus.o_rd_data = bus.i_core_rd_data;
      bus.o_rd_wren = (bus.i_core_rd_addr != 5'd0);
    end
    // Registered scoreboard only: an MDU write landing this cycle still
    // reports a hazard, it drops in the following cycle.
    if (!i_reset) begin
      bus.o_hazard = r_busy[bus.i_rs1_addr] | r_busy[bus.i_rs2_addr] |
                     (bus.i_core_wren & r_busy[bus.i_core_rd_addr]);
    end
  end

  assign bus.o_busy_mask = r_busy;

  // Scoreboard next state: clear on MDU acceptance, then set on issue so a
  // same-cycle set/clear of one register leaves it busy. x0 never busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_grant_mdu) begin
      w_busy_nxt[bus.i_mdu_rd_addr] = 1'b0;
    end
    if (bus.i_issue_valid && (bus.i_issue_rd_addr != 5'd0)) begin
      w_busy_nxt[bus.i_issue_rd_addr] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_busy <= 32'd0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Starvation counter: counts refused MDU cycles, saturating at the limit.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wait_cnt <= 4'd0;
    end else if (!bus.i_mdu_valid || w_grant_mdu) begin
      r_wait_cnt <= 4'd0;
    end else if (r_wait_cnt != c_limit) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed self-checking bench for regfile_wb_arbiter.
//               Inputs change on the falling edge; combinational outputs are
//               checked 1 ns later, registered state after the next edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  logic i_clk;
  logic i_reset;
  int   n_total;
  int   n_bad;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Hard time bound so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic idle();
    bus.i_core_wren     = 1'b0;
    bus.i_core_rd_addr  = 5'd0;
    bus.i_core_rd_data  = 32'd0;
    bus.i_mdu_valid     = 1'b0;
    bus.i_mdu_rd_addr   = 5'd0;
    bus.i_mdu_rd_data   = 32'd0;
    bus.i_issue_valid   = 1'b0;
    bus.i_issue_rd_addr = 5'd0;
    bus.i_rs1_addr      = 5'd0;
    bus.i_rs2_addr      = 5'd0;
  endtask

  task automatic step();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic core_wr(input logic [4:0] a, input logic [31:0] d);
    bus.i_core_wren    = 1'b1;
    bus.i_core_rd_addr = a;
    bus.i_core_rd_data = d;
  endtask

  task automatic mdu_wr(input logic [4:0] a, input logic [31:0] d);
    bus.i_mdu_valid   = 1'b1;
    bus.i_mdu_rd_addr = a;
    bus.i_mdu_rd_data = d;
  endtask

  task automatic issue(input logic [4:0] a);
    bus.i_issue_valid   = 1'b1;
    bus.i_issue_rd_addr = a;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;

    // ---------------- Reset with every request active ----------------
    idle();
    i_reset = 1'b1;
    core_wr(5'd3, 32'h1);
    mdu_wr(5'd4, 32'h2);
    issue(5'd5);
    bus.i_rs1_addr = 5'd5;
    bus.i_rs2_addr = 5'd4;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("rst_wren",  32'(bus.o_rd_wren), 32'd0);
      check("rst_ready", 32'(bus.o_mdu_ready), 32'd0);
      check("rst_stall", 32'(bus.o_core_stall), 32'd0);
      check("rst_hazard", 32'(bus.o_hazard), 32'd0);
      check("rst_addr",  32'(bus.o_rd_addr), 32'd0);
      check("rst_data",  bus.o_rd_data, 32'd0);
      step();
      check("rst_busy",  bus.o_busy_mask, 32'd0);
      check("rst_wait",  32'(dut.r_wait_cnt), 32'd0);
    end
    i_reset = 1'b0;
    idle();
    #1;
    check("rel_busy", bus.o_busy_mask, 32'd0);
    step();

    // ---------------- Priority: core beats MDU ----------------
    core_wr(5'd5, 32'h11111111);
    mdu_wr(5'd6, 32'h22222222);
    #1;
    check("pri_wren",  32'(bus.o_rd_wren), 32'd1);
    check("pri_addr",  32'(bus.o_rd_addr), 32'd5);
    check("pri_data",  bus.o_rd_data, 32'h11111111);
    check("pri_ready", 32'(bus.o_mdu_ready), 32'd0);
    step();
    bus.i_core_wren = 1'b0;
    #1;
    check("pri2_addr",  32'(bus.o_rd_addr), 32'd6);
    check("pri2_data",  bus.o_rd_data, 32'h22222222);
    check("pri2_ready", 32'(bus.o_mdu_ready), 32'd1);
    check("pri2_wait",  32'(dut.r_wait_cnt), 32'd1);
    step();
    idle();
    #1;
    check("pri_wait_clr", 32'(dut.r_wait_cnt), 32'd0);
    step();

    // ---------------- Starvation, limit 4 ----------------
    for (int k = 1; k <= 5; k++) begin
      core_wr(5'(10 + k), 32'(k));
      mdu_wr(5'd12, 32'hCAFE0012);
      #1;
      check("stv_wait", 32'(dut.r_wait_cnt), 32'(k - 1));
      if (k < 5) begin
        check("stv_ready", 32'(bus.o_mdu_ready), 32'd0);
        check("stv_stall", 32'(bus.o_core_stall), 32'd0);
        check("stv_addr",  32'(bus.o_rd_addr), 32'(10 + k));
      end else begin
        check("stv_f_ready", 32'(bus.o_mdu_ready), 32'd1);
        check("stv_f_stall", 32'(bus.o_core_stall), 32'd1);
        check("stv_f_addr",  32'(bus.o_rd_addr), 32'd12);
        check("stv_f_data",  bus.o_rd_data, 32'hCAFE0012);
        check("stv_f_wren",  32'(bus.o_rd_wren), 32'd1);
      end
      step();
    end
    bus.i_mdu_valid = 1'b0;
    core_wr(5'd20, 32'h20);
    #1;
    check("stv_post_wait",  32'(dut.r_wait_cnt), 32'd0);
    check("stv_post_stall", 32'(bus.o_core_stall), 32'd0);
    check("stv_post_addr",  32'(bus.o_rd_addr), 32'd20);
    step();

    // ---------------- Reset in the middle of an MDU wait ----------------
    core_wr(5'd1, 32'h1);
    mdu_wr(5'd2, 32'h2);
    step();
    step();
    i_reset = 1'b1;
    #1;
    check("mrst_ready", 32'(bus.o_mdu_ready), 32'd0);
    check("mrst_wren",  32'(bus.o_rd_wren), 32'd0);
    step();
    check("mrst_wait",  32'(dut.r_wait_cnt), 32'd0);
    i_reset = 1'b0;
    idle();
    step();

    // ---------------- Scoreboard / hazard on x7 ----------------
    issue(5'd7);
    bus.i_rs1_addr = 5'd7;
    #1;
    check("sb_haz_issue", 32'(bus.o_hazard), 32'd0);
    step();
    idle();
    bus.i_rs1_addr = 5'd7;
    #1;
    check("sb_haz_rs1", 32'(bus.o_hazard), 32'd1);
    check("sb_busy7",   bus.o_busy_mask, 32'h00000080);
    bus.i_rs1_addr = 5'd0;
    bus.i_rs2_addr = 5'd7;
    #1;
    check("sb_haz_rs2", 32'(bus.o_hazard), 32'd1);
    bus.i_rs2_addr = 5'd0;
    core_wr(5'd7, 32'h7);
    #1;
    check("sb_haz_core", 32'(bus.o_hazard), 32'd1);
    step();
    idle();
    bus.i_rs1_addr = 5'd7;
    mdu_wr(5'd7, 32'h77);
    #1;
    check("sb_haz_acc",   32'(bus.o_hazard), 32'd1);
    check("sb_acc_ready", 32'(bus.o_mdu_ready), 32'd1);
    check("sb_acc_addr",  32'(bus.o_rd_addr), 32'd7);
    step();
    bus.i_mdu_valid = 1'b0;
    #1;
    check("sb_haz_clr", 32'(bus.o_hazard), 32'd0);
    check("sb_busy_clr", bus.o_busy_mask, 32'd0);
    step();
    idle();

    // ---------------- Same-cycle set/clear on x9 ----------------
    issue(5'd9);
    step();
    idle();
    mdu_wr(5'd9, 32'h99);
    issue(5'd9);
    #1;
    check("sc_ready", 32'(bus.o_mdu_ready), 32'd1);
    check("sc_wren",  32'(bus.o_rd_wren), 32'd1);
    check("sc_data",  bus.o_rd_data, 32'h99);
    step();
    idle();
    #1;
    check("sc_busy9", bus.o_busy_mask, 32'h00000200);
    mdu_wr(5'd9, 32'h9A);
    step();
    idle();
    #1;
    check("sc_busy_clr", bus.o_busy_mask, 32'd0);
    step();

    // ---------------- x0 handling ----------------
    issue(5'd0);
    step();
    idle();
    #1;
    check("x0_busy", bus.o_busy_mask, 32'd0);
    mdu_wr(5'd0, 32'h5);
    #1;
    check("x0_mdu_ready", 32'(bus.o_mdu_ready), 32'd1);
    check("x0_mdu_wren",  32'(bus.o_rd_wren), 32'd0);
    step();
    idle();
    core_wr(5'd0, 32'h6);
    #1;
    check("x0_core_wren",  32'(bus.o_rd_wren), 32'd0);
    check("x0_core_stall", 32'(bus.o_core_stall), 32'd0);
    step();
    idle();
    #1;
    check("x0_busy_end", bus.o_busy_mask, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and scoreboard for the single-write-port 32×32 register file of the RV32I single-cycle core. It merges two write sources onto the one write port: the core's single-cycle result path, and a multi-cycle unit (MDU: mul/div or slow load) that returns results later with a valid/ready handshake. It tracks which destination registers have an outstanding MDU result and flags read-after-write and write-after-write hazards to the core. A starvation counter guarantees MDU forward progress by stalling the core.

## Interface
- STARVE_LIMIT, default 4: consecutive MDU wait cycles before the MDU is forced through; legal range 1..15.

- i_clk  in  1  clock, rising edge
- i_reset  in  1  synchronous, active-high reset
- i_core_wren  in  1  core write request (no handshake)
- i_core_rd_addr  in  5  core destination register
- i_core_rd_data  in  32  core write data
- i_mdu_valid  in  1  MDU result valid; addr/data held stable until accepted
- i_mdu_rd_addr  in  5  MDU destination register
- i_mdu_rd_data  in  32  MDU write data
- o_mdu_ready  out  1  MDU result accepted this cycle
- i_issue_valid  in  1  core issues an MDU op this cycle
- i_issue_rd_addr  in  5  destination of the issued MDU op
- i_rs1_addr  in  5  source register 1 being read by the core
- i_rs2_addr  in  5  source register 2 being read by the core
- o_hazard  out  1  core must stall: a source or destination is pending
- o_core_stall  out  1  core write refused this cycle (starvation override)
- o_busy_mask  out  32  registered scoreboard, bit n = xn pending
- o_rd_wren  out  1  to register file write enable
- o_rd_addr  out  5  to register file write address
- o_rd_data  out  32  to register file write data

## Operation
- Grant (combinational, each cycle):
  - force = i_mdu_valid && (wait_cnt == STARVE_LIMIT).
  - If force: MDU granted, o_core_stall = i_core_wren, core write dropped (the core re-presents it next cycle).
  - Else if i_core_wren: core granted, o_mdu_ready = 0.
  - Else if i_mdu_valid: MDU granted, o_mdu_ready = 1.
- Write port mux: the granted source drives o_rd_addr/o_rd_data. o_rd_wren = grant && addr != 0. An MDU result to x0 is still accepted (o_mdu_ready=1) without a write.
- wait_cnt (4-bit register):
  - Increments when i_mdu_valid && !o_mdu_ready.
  - Clears to 0 on MDU acceptance or when i_mdu_valid = 0.
  - Saturates at STARVE_LIMIT.
- Scoreboard busy[31:0] (register):
  - Set busy[i_issue_rd_addr] on i_issue_valid, only if the address is non-zero.
  - Clear busy[i_mdu_rd_addr] on MDU acceptance.
  - Set and clear of the same register in the same cycle: set wins (bit stays 1).
  - Issue to an already-busy register is illegal. The core prevents it via o_hazard.
  - busy[0] is always 0.
- o_hazard = busy[i_rs1_addr] | busy[i_rs2_addr] | (i_core_wren & busy[i_core_rd_addr]). It uses registered busy, with no bypass of a same-cycle MDU write.
- o_busy_mask = busy.

## Timing
- Reset (i_reset=1 at a rising edge):
  - busy = 0 and wait_cnt = 0 after the edge.
  - While i_reset is high, o_rd_wren, o_mdu_ready, o_core_stall and o_hazard are forced to 0. o_rd_addr and o_rd_data are 0.
  - A reset mid-wait drops the pending MDU handshake with no write; the MDU must re-present after reset.
- Write path latency: 0 cycles. Inputs reach the regfile port combinationally, and the regfile commits at the same rising edge.
- MDU handshake: transfer occurs on a cycle with i_mdu_valid && o_mdu_ready. The busy bit clears at that edge, and o_hazard for that register falls in the following cycle.
- Issue: the busy bit is visible (o_hazard, o_busy_mask) the cycle after i_issue_valid.
- Starvation bound: an MDU result waits at most STARVE_LIMIT cycles. It is accepted in cycle STARVE_LIMIT+1 after it first asserts valid.
- o_core_stall is high for exactly one cycle per force event, and only if the core was writing.

## Test plan
- Reset: hold i_reset 2 cycles with all requests active. Required: o_rd_wren=0, o_mdu_ready=0, o_busy_mask=0 throughout and after release.
- Priority: i_core_wren=1 (x5, 0x11111111) and i_mdu_valid=1 (x6, 0x22222222) in the same cycle. Required: x5 is written and o_mdu_ready=0. Next cycle with core idle: x6 is written and o_mdu_ready=1.
- Starvation, STARVE_LIMIT=4: core writes every cycle with MDU valid. Required: wait_cnt counts 1..4; in the 5th cycle o_core_stall=1, the MDU value is written and the core write is dropped; wait_cnt returns to 0.
- Scoreboard/hazard: issue rd=x7, then present rs1=x7. Required: o_hazard=1 from the cycle after issue until the cycle after the MDU write to x7 is accepted, then 0. Core write to x7 while busy also gives o_hazard=1.
- Same-cycle set/clear: MDU accept on x9 and a new issue to x9 in one cycle. Required: busy[9] stays 1 and x9 is written.
- x0 handling: issue rd=x0, then MDU result to x0 and core write to x0. Required: busy[0]=0, o_mdu_ready=1, o_rd_wren=0 in both cases.
